// File: rtl/instr_mem_pkg.sv
// Shared opcodes, fill word and controller state encoding for the instruction store.
package instr_mem_pkg;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h5;
    localparam logic [3:0] OP_STORE = 4'h6;
    localparam logic [3:0] OP_LI    = 4'h7;
    localparam logic [3:0] OP_NOP   = 4'hF;

    localparam logic [15:0] NOP_WORD = {OP_NOP, 12'h000};

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        LOAD = 2'd2
    } state_t;

endpackage

// File: rtl/instr_mem_array.sv
// Single-port synchronous instruction RAM; read data updates only on en and holds otherwise.
module instr_mem_array #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 256
) (
    input  logic               clk,
    input  logic               we,
    input  logic               en,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [INSTR_W-1:0] wdata,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction store with NOP sweep after reset, streaming program load and a
// one-cycle-latency fetch port. Handshakes: a fetch transfers when fetch_req & fetch_gnt;
// a returned word is consumed when instr_valid & instr_ready; a load word when ld_valid & ld_ready.
module instr_mem_loader
    import instr_mem_pkg::*;
#(
    parameter int                 ADDR_W   = 8,
    parameter int                 INSTR_W  = 16,
    parameter int                 DEPTH    = 256,
    parameter logic [INSTR_W-1:0] NOP_WORD = instr_mem_pkg::NOP_WORD
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_req,
    input  logic [ADDR_W-1:0]  fetch_addr,
    output logic               fetch_gnt,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_oob,
    input  logic               instr_ready,
    input  logic               ld_start,
    input  logic [ADDR_W-1:0]  ld_base,
    input  logic               ld_valid,
    input  logic [INSTR_W-1:0] ld_data,
    input  logic               ld_last,
    output logic               ld_ready,
    output logic               ld_ovf,
    output logic               mem_ready,
    output logic [1:0]         dbg_state
);

    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t             state;
    logic [ADDR_W-1:0]  init_ptr;
    logic [ADDR_W-1:0]  ld_ptr;
    logic [ADDR_W-1:0]  wr_addr;
    logic [ADDR_W-1:0]  ram_addr;
    logic [INSTR_W-1:0] ram_wdata;
    logic [INSTR_W-1:0] ram_rdata;
    logic               ram_we;
    logic               ram_en;
    logic               ptr_oob;
    logic               fetch_oob;
    logic               show_nop;

    // A load base beyond the array folds to address 0 on its first write.
    assign ptr_oob   = ({1'b0, ld_ptr} >= DEPTH_X);
    assign wr_addr   = ptr_oob ? '0 : ld_ptr;
    assign fetch_oob = ({1'b0, fetch_addr} >= DEPTH_X);

    assign fetch_gnt = (state == IDLE) & fetch_req & ~ld_start & (~instr_valid | instr_ready);

    assign ram_we    = (state == INIT) | ((state == LOAD) & ld_valid);
    assign ram_en    = fetch_gnt & ~fetch_oob;
    assign ram_wdata = (state == INIT) ? NOP_WORD : ld_data;

    always_comb begin
        ram_addr = fetch_addr;
        case (state)
            INIT:    ram_addr = init_ptr;
            LOAD:    ram_addr = wr_addr;
            default: ram_addr = fetch_addr;
        endcase
    end

    // RAM read data holds between grants, so it doubles as the instr holding register.
    assign instr     = show_nop ? NOP_WORD : ram_rdata;
    assign dbg_state = state;

    instr_mem_array #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .en    (ram_en),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= INIT;
            init_ptr    <= '0;
            ld_ptr      <= '0;
            ld_ovf      <= 1'b0;
            ld_ready    <= 1'b0;
            mem_ready   <= 1'b0;
            instr_valid <= 1'b0;
            instr_oob   <= 1'b0;
            show_nop    <= 1'b1;
        end else begin
            if (fetch_gnt) begin
                instr_valid <= 1'b1;
                instr_oob   <= fetch_oob;
                show_nop    <= fetch_oob;
            end else if (instr_ready) begin
                instr_valid <= 1'b0;
                instr_oob   <= 1'b0;
                show_nop    <= 1'b1;
            end

            case (state)
                INIT: begin
                    if (init_ptr == LAST_ADDR) begin
                        state     <= IDLE;
                        mem_ready <= 1'b1;
                    end else begin
                        init_ptr <= init_ptr + 1'b1;
                    end
                end
                IDLE: begin
                    if (ld_start) begin
                        state     <= LOAD;
                        ld_ptr    <= ld_base;
                        ld_ovf    <= 1'b0;
                        ld_ready  <= 1'b1;
                        mem_ready <= 1'b0;
                    end
                end
                LOAD: begin
                    if (ld_valid) begin
                        if (wr_addr == LAST_ADDR) begin
                            ld_ptr <= '0;
                            ld_ovf <= 1'b1;
                        end else begin
                            ld_ptr <= wr_addr + 1'b1;
                        end
                        if (ptr_oob) begin
                            ld_ovf <= 1'b1;
                        end
                        if (ld_last) begin
                            state     <= IDLE;
                            ld_ready  <= 1'b0;
                            mem_ready <= 1'b1;
                        end
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench: a DEPTH=256 store plus a DEPTH=200 store driven by the same stimulus.
module tb_instr_mem_loader;

    localparam logic [1:0] S_INIT = 2'd0;
    localparam logic [1:0] S_IDLE = 2'd1;
    localparam logic [1:0] S_LOAD = 2'd2;
    localparam logic [15:0] NOP  = 16'hF000;

    logic        clk;
    logic        rst_n;
    logic        fetch_req;
    logic [7:0]  fetch_addr;
    logic        instr_ready;
    logic        ld_start;
    logic [7:0]  ld_base;
    logic        ld_valid;
    logic [15:0] ld_data;
    logic        ld_last;

    logic        fetch_gnt, instr_valid, instr_oob, ld_ready, ld_ovf, mem_ready;
    logic [15:0] instr;
    logic [1:0]  dbg_state;

    logic        s_fetch_gnt, s_instr_valid, s_instr_oob, s_ld_ready, s_ld_ovf, s_mem_ready;
    logic [15:0] s_instr;
    logic [1:0]  s_dbg_state;

    int total;
    int bad;
    int n;

    instr_mem_loader dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .instr_valid(instr_valid), .instr(instr), .instr_oob(instr_oob), .instr_ready(instr_ready),
        .ld_start(ld_start), .ld_base(ld_base), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_last(ld_last), .ld_ready(ld_ready), .ld_ovf(ld_ovf), .mem_ready(mem_ready),
        .dbg_state(dbg_state)
    );

    instr_mem_loader #(.DEPTH(200)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(s_fetch_gnt),
        .instr_valid(s_instr_valid), .instr(s_instr), .instr_oob(s_instr_oob), .instr_ready(instr_ready),
        .ld_start(ld_start), .ld_base(ld_base), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_last(ld_last), .ld_ready(s_ld_ready), .ld_ovf(s_ld_ovf), .mem_ready(s_mem_ready),
        .dbg_state(s_dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!mem_ready && cnt < 400) begin
            cyc();
            cnt++;
        end
    endtask

    task automatic fetch1(input string tag, input logic [7:0] a, input logic [15:0] e_instr, input logic e_oob);
        fetch_addr = a;
        fetch_req  = 1'b1;
        #1 chk({tag, "_gnt"}, fetch_gnt, 1'b1);
        cyc();
        fetch_req = 1'b0;
        chk({tag, "_valid"}, instr_valid, 1'b1);
        chk({tag, "_instr"}, instr, e_instr);
        chk({tag, "_oob"}, instr_oob, e_oob);
    endtask

    task automatic load_start(input logic [7:0] b);
        ld_start = 1'b1;
        ld_base  = b;
        cyc();
        ld_start = 1'b0;
        chk("ld_enter_state", dbg_state, S_LOAD);
        chk("ld_enter_ready", ld_ready, 1'b1);
    endtask

    task automatic load_word(input logic [15:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        cyc();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        fetch_req = 1'b0; fetch_addr = '0; instr_ready = 1'b1;
        ld_start = 1'b0; ld_base = '0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        repeat (3) cyc();

        chk("rst_state", dbg_state, S_INIT);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_instr", instr, NOP);
        chk("rst_oob", instr_oob, 1'b0);
        chk("rst_ovf", ld_ovf, 1'b0);
        chk("rst_gnt", fetch_gnt, 1'b0);
        chk("rst_ld_ready", ld_ready, 1'b0);
        chk("rst_mem_ready", mem_ready, 1'b0);

        // NOP sweep lasts DEPTH cycles; fetches during it are ignored
        rst_n = 1'b1;
        n = 0;
        while (!mem_ready && n < 400) begin
            cyc();
            n++;
            if (n == 10) begin
                fetch_req = 1'b1;
                #1 chk("init_gnt", fetch_gnt, 1'b0);
                fetch_req = 1'b0;
            end
        end
        chk("init_cycles", n, 256);
        chk("init_state", dbg_state, S_IDLE);
        chk("s_init_ready", s_mem_ready, 1'b1);

        fetch1("sweep00", 8'h00, NOP, 1'b0);
        fetch1("sweep80", 8'h80, NOP, 1'b0);
        fetch1("sweepff", 8'hFF, NOP, 1'b0);
        chk("s_sweepff_oob", s_instr_oob, 1'b1);

        // load three words at base 0, then read back-to-back
        load_start(8'h00);
        load_word(16'h0123, 1'b0);
        load_word(16'h1456, 1'b0);
        chk("ld_mid_state", dbg_state, S_LOAD);
        load_word(16'h7509, 1'b1);
        chk("ld_done_state", dbg_state, S_IDLE);
        chk("ld_done_ready", ld_ready, 1'b0);
        chk("ld_done_ovf", ld_ovf, 1'b0);

        fetch_addr = 8'h00; fetch_req = 1'b1;
        cyc();
        chk("b2b0_instr", instr, 16'h0123);
        fetch_addr = 8'h01;
        #1 chk("b2b1_gnt", fetch_gnt, 1'b1);
        cyc();
        chk("b2b1_valid", instr_valid, 1'b1);
        chk("b2b1_instr", instr, 16'h1456);
        fetch_addr = 8'h02;
        cyc();
        chk("b2b2_instr", instr, 16'h7509);
        chk("s_b2b2_instr", s_instr, 16'h7509);
        fetch_req = 1'b0;
        cyc();

        // backpressure holds the word and blocks further grants
        instr_ready = 1'b0;
        fetch_addr = 8'h01; fetch_req = 1'b1;
        cyc();
        chk("bp_first", instr, 16'h1456);
        fetch_addr = 8'h02;
        for (int i = 0; i < 5; i++) begin
            #1 chk("bp_gnt", fetch_gnt, 1'b0);
            cyc();
            chk("bp_hold_instr", instr, 16'h1456);
            chk("bp_hold_valid", instr_valid, 1'b1);
        end
        instr_ready = 1'b1;
        #1 chk("bp_release_gnt", fetch_gnt, 1'b1);
        cyc();
        chk("bp_next_instr", instr, 16'h7509);
        fetch_req = 1'b0;
        cyc();
        chk("bp_cleared", instr_valid, 1'b0);

        // wrap past DEPTH-1; the 200-deep copy folds base FE to 0
        load_start(8'hFE);
        load_word(16'h0A0A, 1'b0);
        load_word(16'h0B0B, 1'b0);
        load_word(16'h0C0C, 1'b1);
        chk("wrap_ovf", ld_ovf, 1'b1);
        chk("s_wrap_ovf", s_ld_ovf, 1'b1);
        fetch1("wrapfe", 8'hFE, 16'h0A0A, 1'b0);
        chk("s_wrapfe_oob", s_instr_oob, 1'b1);
        chk("s_wrapfe_instr", s_instr, NOP);
        fetch1("wrapff", 8'hFF, 16'h0B0B, 1'b0);
        fetch1("wrap00", 8'h00, 16'h0C0C, 1'b0);
        chk("s_wrap00_instr", s_instr, 16'h0A0A);
        fetch1("wrap02", 8'h02, 16'h7509, 1'b0);
        chk("s_wrap02_instr", s_instr, 16'h0C0C);

        // ld_start beats fetch_req; a second ld_start inside LOAD is ignored
        fetch_addr = 8'h00; fetch_req = 1'b1;
        ld_start = 1'b1; ld_base = 8'h10;
        #1 chk("cont_gnt", fetch_gnt, 1'b0);
        cyc();
        chk("cont_state", dbg_state, S_LOAD);
        chk("cont_ovf_cleared", ld_ovf, 1'b0);
        chk("cont_ld_ready", ld_ready, 1'b1);
        fetch_req = 1'b0;
        ld_base = 8'h50;
        ld_valid = 1'b1; ld_data = 16'h5123; ld_last = 1'b0;
        cyc();
        ld_start = 1'b0;
        ld_data = 16'h6234; ld_last = 1'b1;
        cyc();
        ld_valid = 1'b0; ld_last = 1'b0;
        chk("cont_done_state", dbg_state, S_IDLE);
        fetch1("cont10", 8'h10, 16'h5123, 1'b0);
        fetch1("cont11", 8'h11, 16'h6234, 1'b0);
        fetch1("cont50", 8'h50, NOP, 1'b0);

        // address 0xC8 is out of range only for the 200-deep copy
        fetch1("oobc8", 8'hC8, NOP, 1'b0);
        chk("s_oobc8_instr", s_instr, NOP);
        chk("s_oobc8_oob", s_instr_oob, 1'b1);
        chk("s_oobc8_valid", s_instr_valid, 1'b1);
        cyc();

        // reset in the middle of a load
        load_start(8'hFF);
        load_word(16'h1111, 1'b0);
        chk("mid_ovf_set", ld_ovf, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state", dbg_state, S_INIT);
        chk("mid_rst_ovf", ld_ovf, 1'b0);
        chk("mid_rst_ld_ready", ld_ready, 1'b0);
        chk("mid_rst_mem_ready", mem_ready, 1'b0);
        cyc();
        rst_n = 1'b1;
        wait_ready(n);
        chk("mid_init_cycles", n, 256);
        chk("mid_after_ovf", ld_ovf, 1'b0);
        fetch1("mid_ff", 8'hFF, NOP, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
